emmc_cmd_line: RTL

Core-side controller for the eMMC CMD line, on the other side of the bidirectional CMD pad buffer. It takes a command (index, argument, response type) and serialises the 48-bit frame with CRC7, MSB first, driving the pad's data and output-enable inputs. It then releases the line, waits for the card's response start bit with a timeout, and deserialises a 48- or 136-bit response. It returns the response to the host-side register block with CRC/end-bit status.

---
 rtl/emmc_cmd_line.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/emmc_cmd_line.sv
// eMMC CMD-line controller: sends a 48-bit command frame with CRC7, then collects the card response.
// Latency: 48 bit_en to send + 1 to release, then 2 turnaround, up to NCR_MAX wait, 47/135 receive; resp_valid 1 clk later.
// Backpressure: cmd_ready is high only while idle; a cmd_valid seen in any other state is ignored.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   bit_en                one-clk strobe per eMMC bit period; all line activity advances on it
//   cmd_valid/cmd_ready   command handshake; cmd_index, cmd_arg, resp_type are latched on accept
//   resp_valid            one-clk completion pulse; resp_data, resp_crc_err, resp_timeout hold until the next one
//   pad_out/pad_oe/pad_in CMD pad buffer: data to drive, output enable (1 = drive), received level
module emmc_cmd_line #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_en,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         resp_crc_err,
  output logic         resp_timeout,
  output logic         pad_out,
  output logic         pad_oe,
  input  logic         pad_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_WAIT,
    S_RX,
    S_DONE
  } state_t;

  // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t         r_state;
  logic [47:0]    r_tx_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]     r_rtype;
  logic [127:0]   r_rx;
  logic           r_to;

  logic           r_cmd_ready;
  logic           r_resp_valid;
  logic [127:0]   r_resp_data;
  logic           r_resp_crc_err;
  logic           r_resp_timeout;
  logic           r_pad_out;
  logic           r_pad_oe;

  logic [39:0]      w_hdr;
  logic [47:0]      w_frame;
  logic             w_rx48_err;
  logic [CNT_W-1:0] w_rx_last;
  logic [CNT_W-1:0] w_ncr_last;

  assign w_hdr      = {2'b01, cmd_index, cmd_arg};
  assign w_frame    = {w_hdr, crc7(w_hdr), 1'b1};
  // For a 48-bit response the start bit is implicit at r_rx[47] (the register is cleared on start).
  assign w_rx48_err = (crc7(r_rx[47:8]) != r_rx[7:1]) | ~r_rx[0];
  // The start bit is counted as bit 0, so RX ends when the counter reaches frame length - 1.
  assign w_rx_last  = (r_rtype == 2'b10) ? CNT_W'(135) : CNT_W'(47);
  assign w_ncr_last = CNT_W'(NCR_MAX - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tx_sh        <= '0;
      r_cnt          <= '0;
      r_rtype        <= 2'b00;
      r_rx           <= '0;
      r_to           <= 1'b0;
      r_cmd_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= '0;
      r_resp_crc_err <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_pad_out      <= 1'b1;
      r_pad_oe       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pad_oe  <= 1'b0;
          r_pad_out <= 1'b1;
          // A bit_en on the accept edge is deliberately not used: the first frame bit waits for the next one.
          if (cmd_valid) begin
            r_tx_sh     <= w_frame;
            r_rtype     <= (resp_type == 2'b11) ? 2'b01 : resp_type;
            r_cnt       <= '0;
            r_to        <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= S_TX;
          end
        end

        S_TX: begin
          if (bit_en) begin
            if (r_cnt == CNT_W'(48)) begin
              // All 48 bits are out; this bit period releases the line.
              r_pad_oe  <= 1'b0;
              r_pad_out <= 1'b1;
              r_cnt     <= '0;
              r_state   <= (r_rtype == 2'b00) ? S_DONE : S_TURN;
            end else begin
              r_pad_oe  <= 1'b1;
              r_pad_out <= r_tx_sh[47];
              r_tx_sh   <= {r_tx_sh[46:0], 1'b0};
              r_cnt     <= r_cnt + 1'b1;
            end
          end
        end

        S_TURN: begin
          if (bit_en) begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (bit_en) begin
            if (!pad_in) begin
              r_rx    <= '0;
              r_cnt   <= CNT_W'(1);
              r_state <= S_RX;
            end else if (r_cnt == w_ncr_last) begin
              r_to    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_RX: begin
          if (bit_en) begin
            r_rx <= {r_rx[126:0], pad_in};
            if (r_cnt == w_rx_last) begin
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_resp_valid   <= 1'b1;
          r_resp_timeout <= r_to;
          if (r_to || (r_rtype == 2'b00)) begin
            r_resp_data    <= '0;
            r_resp_crc_err <= 1'b0;
          end else if (r_rtype == 2'b10) begin
            // Long responses carry no CRC check here; only the end bit is validated.
            r_resp_data    <= r_rx;
            r_resp_crc_err <= ~r_rx[0];
          end else begin
            r_resp_data    <= {80'b0, r_rx[47:0]};
            r_resp_crc_err <= w_rx48_err;
          end
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_cmd_ready <= 1'b1;
          r_pad_oe    <= 1'b0;
          r_pad_out   <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_crc_err = r_resp_crc_err;
  assign resp_timeout = r_resp_timeout;
  assign pad_out      = r_pad_out;
  assign pad_oe       = r_pad_oe;

endmodule
